// File: rtl/cursor_pkg.sv
// Shared constants for the cursor controller: button indices, repeat FSM
// encoding and the clamp/wrap step arithmetic.
package cursor_pkg;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam logic [1:0] RPT_IDLE   = 2'd0;
  localparam logic [1:0] RPT_DELAY  = 2'd1;
  localparam logic [1:0] RPT_REPEAT = 2'd2;

  // One step of size stp along an axis of extent res; stp < res keeps a
  // single correction sufficient for the wrap case.
  function automatic int step_pos(input int pos, input int res, input int stp,
                                  input logic inc, input logic wrap);
    int sum;
    if (inc) begin
      sum = pos + stp;
      if (sum > res - 1) sum = wrap ? sum - res : res - 1;
    end else begin
      sum = pos - stp;
      if (sum < 0) sum = wrap ? sum + res : 0;
    end
    return sum;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus level debouncer for one active-low push-button;
// level is the accepted active-high pressed state.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clock,
  input  logic resetn,
  input  logic btn_n,
  output logic level
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  // Synchroniser resets to the released level so a button held through reset
  // is debounced as a fresh press.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      cnt    <= CNT_LOAD;
      level  <= 1'b0;
    end else begin
      sync_a <= btn_n;
      sync_b <= sync_a;
      if (~sync_b == level) begin
        cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
        level <= ~sync_b;
        cnt   <= CNT_LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// Four-button cursor controller: debounced buttons drive a clamped or wrapped
// (x, y) position. Hold-to-repeat is built only with CURSOR_AUTOREPEAT_EN.
//
// state      | meaning
// RPT_IDLE   | axis idle or waiting for a press event
// RPT_DELAY  | stepped on press, counting down to first repeat
// RPT_REPEAT | stepping once per repeat period while held
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int STEP       = 4,
  parameter int DEB_CYCLES = 250000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000,
  parameter int WRAP       = 0
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     up,
  input  logic                     down,
  input  logic                     left,
  input  logic                     right,
  output logic [$clog2(H_RES)-1:0] x_pos,
  output logic [$clog2(V_RES)-1:0] y_pos,
  output logic [3:0]               held,
  output logic                     moved
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);

  logic [3:0]    lvl;
  logic [3:0]    lvl_q;
  logic [3:0]    press;
  logic [1:0]    act;
  logic [1:0]    prs;
  logic [1:0]    step;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clock(clock), .resetn(resetn), .btn_n(up), .level(lvl[DIR_UP]));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clock(clock), .resetn(resetn), .btn_n(down), .level(lvl[DIR_DOWN]));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clock(clock), .resetn(resetn), .btn_n(left), .level(lvl[DIR_LEFT]));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clock(clock), .resetn(resetn), .btn_n(right), .level(lvl[DIR_RIGHT]));

  assign held  = lvl;
  assign press = lvl & ~lvl_q;

  // Index 0 is the x axis, index 1 the y axis; both buttons down cancels the axis.
  assign act[0] = lvl[DIR_LEFT] ^ lvl[DIR_RIGHT];
  assign act[1] = lvl[DIR_UP] ^ lvl[DIR_DOWN];
  assign prs[0] = act[0] & (press[DIR_LEFT] | press[DIR_RIGHT]);
  assign prs[1] = act[1] & (press[DIR_UP] | press[DIR_DOWN]);

`ifdef CURSOR_AUTOREPEAT_EN
  localparam int TW = $clog2(((RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD) + 1);
  localparam logic [TW-1:0] DLY_LOAD = TW'(RPT_DELAY - 1);
  localparam logic [TW-1:0] PER_LOAD = TW'(RPT_PERIOD - 1);

  logic [1:0][1:0]    rpt_state;
  logic [1:0][TW-1:0] tmr;

  always_comb begin
    step = '0;
    for (int a = 0; a < 2; a++)
      step[a] = act[a] & (prs[a] | ((rpt_state[a] != RPT_IDLE) && (tmr[a] == '0)));
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rpt_state <= {RPT_IDLE, RPT_IDLE};
      tmr       <= '0;
    end else begin
      for (int a = 0; a < 2; a++) begin
        if (!act[a]) begin
          rpt_state[a] <= RPT_IDLE;
        end else if (prs[a]) begin
          // A fresh press, including a direction swap, restarts the delay.
          rpt_state[a] <= RPT_DELAY;
          tmr[a]       <= DLY_LOAD;
        end else if (rpt_state[a] != RPT_IDLE) begin
          if (tmr[a] == '0) begin
            rpt_state[a] <= RPT_REPEAT;
            tmr[a]       <= PER_LOAD;
          end else begin
            tmr[a] <= tmr[a] - 1'b1;
          end
        end
      end
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = ^{RPT_DELAY, RPT_PERIOD};
  assign step       = prs;
`endif

  always_comb begin
    x_nxt = x_pos;
    y_nxt = y_pos;
    if (step[0])
      x_nxt = XW'(step_pos(int'(x_pos), H_RES, STEP, lvl[DIR_RIGHT], logic'(WRAP != 0)));
    if (step[1])
      y_nxt = YW'(step_pos(int'(y_pos), V_RES, STEP, lvl[DIR_DOWN], logic'(WRAP != 0)));
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_pos <= XW'(H_RES / 2);
      y_pos <= YW'(V_RES / 2);
      moved <= 1'b0;
      lvl_q <= '0;
    end else begin
      x_pos <= x_nxt;
      y_pos <= y_nxt;
      moved <= (x_nxt != x_pos) || (y_nxt != y_pos);
      lvl_q <= lvl;
    end
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: clamp and wrap instances share the buttons;
// expectations follow CURSOR_AUTOREPEAT_EN when it is defined.
`timescale 1ns/1ps
module tb_cursor_ctrl;
  import cursor_pkg::*;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] btn_n;
  logic [3:0] xc, yc, xw, yw;
  logic [3:0] heldc, heldw;
  logic       mvc, mvw;

  int checks = 0;
  int failures = 0;
  int mv_cnt_c = 0;
  int mv_cnt_w = 0;
  int m0c, m0w;
  int glitch_seen;

  int hd_cyc[7] = '{7, 26, 27, 34, 35, 43, 51};
`ifdef CURSOR_AUTOREPEAT_EN
  int hd_c[7] = '{4, 4, 8, 8, 11, 11, 11};
  int hd_w[7] = '{2, 2, 6, 6, 10, 2, 6};
  int rp_c = 15;
  int rp_w = 12;
`else
  int hd_c[7] = '{4, 4, 4, 4, 4, 4, 4};
  int hd_w[7] = '{2, 2, 2, 2, 2, 2, 2};
  int rp_c = 8;
  int rp_w = 4;
`endif

  always #5 clock = ~clock;

  cursor_ctrl #(.H_RES(16), .V_RES(12), .STEP(4), .DEB_CYCLES(4),
                .RPT_DELAY(20), .RPT_PERIOD(8), .WRAP(0)) dut_c (
    .clock(clock), .resetn(resetn),
    .up(btn_n[DIR_UP]), .down(btn_n[DIR_DOWN]),
    .left(btn_n[DIR_LEFT]), .right(btn_n[DIR_RIGHT]),
    .x_pos(xc), .y_pos(yc), .held(heldc), .moved(mvc));

  cursor_ctrl #(.H_RES(16), .V_RES(12), .STEP(4), .DEB_CYCLES(4),
                .RPT_DELAY(20), .RPT_PERIOD(8), .WRAP(1)) dut_w (
    .clock(clock), .resetn(resetn),
    .up(btn_n[DIR_UP]), .down(btn_n[DIR_DOWN]),
    .left(btn_n[DIR_LEFT]), .right(btn_n[DIR_RIGHT]),
    .x_pos(xw), .y_pos(yw), .held(heldw), .moved(mvw));

  always @(posedge clock) begin
    #2;
    if (mvc === 1'b1) mv_cnt_c = mv_cnt_c + 1;
    if (mvw === 1'b1) mv_cnt_w = mv_cnt_w + 1;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic tap(input int idx);
    btn_n[idx] = 1'b0;
    cyc(10);
    btn_n[idx] = 1'b1;
    cyc(12);
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    resetn = 1'b0;
    btn_n  = 4'hF;
    cyc(3);
    check_val("rst_x_c", xc, 8);
    check_val("rst_y_c", yc, 6);
    check_val("rst_x_w", xw, 8);
    check_val("rst_y_w", yw, 6);
    check_val("rst_held", heldc, 0);
    check_val("rst_moved", mvc, 0);
    resetn = 1'b1;

    m0c = mv_cnt_c; m0w = mv_cnt_w;
    cyc(50);
    check_val("idle_moved_c", mv_cnt_c - m0c, 0);
    check_val("idle_moved_w", mv_cnt_w - m0w, 0);
    check_val("idle_x", xc, 8);
    check_val("idle_y", yc, 6);

    // Three-cycle glitch must not be accepted.
    glitch_seen = 0;
    btn_n[DIR_RIGHT] = 1'b0;
    cyc(3);
    btn_n[DIR_RIGHT] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (heldc != 4'b0000) glitch_seen = 1;
    end
    check_val("glitch_held", glitch_seen, 0);
    check_val("glitch_x", xc, 8);

    // Raw edge to position: 2 sync + 4 debounce + 1 register.
    btn_n[DIR_RIGHT] = 1'b0;
    cyc(6);
    check_val("lat_held_e6", heldc, 4'b0001);
    check_val("lat_x_e6", xc, 8);
    cyc(1);
    check_val("lat_x_c_e7", xc, 12);
    check_val("lat_x_w_e7", xw, 12);
    check_val("lat_moved_e7", mvc, 1);
    cyc(1);
    check_val("lat_moved_e8", mvc, 0);
    cyc(2);
    btn_n[DIR_RIGHT] = 1'b1;
    cyc(12);
    check_val("release_x", xc, 12);

    tap(DIR_LEFT);
    tap(DIR_LEFT);
    check_val("left2_x_c", xc, 4);
    check_val("left2_x_w", xw, 4);
    tap(DIR_LEFT);
    check_val("left3_x_c", xc, 0);
    check_val("left3_x_w", xw, 0);
    m0c = mv_cnt_c; m0w = mv_cnt_w;
    tap(DIR_LEFT);
    check_val("left4_x_c", xc, 0);
    check_val("left4_x_w", xw, 12);
    check_val("left4_moved_c", mv_cnt_c - m0c, 0);
    check_val("left4_moved_w", mv_cnt_w - m0w, 1);

    tap(DIR_UP);
    tap(DIR_UP);
    check_val("up2_y_c", yc, 0);
    check_val("up2_y_w", yw, 10);

    // Hold down: step at debounce, then +20, +28, +36, +44 when repeating.
    btn_n[DIR_DOWN] = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      cyc(1);
      if (c == 50) btn_n[DIR_DOWN] = 1'b1;
      for (int k = 0; k < 7; k++) begin
        if (c == hd_cyc[k]) begin
          check_val($sformatf("hold_y_c@%0d", c), yc, hd_c[k]);
          check_val($sformatf("hold_y_w@%0d", c), yw, hd_w[k]);
        end
      end
    end
    cyc(8);
    check_val("hold_end_y_c", yc, hd_c[6]);
    check_val("hold_end_y_w", yw, hd_w[6]);

    // Up and down together cancel y; a right press still moves x.
    m0c = mv_cnt_c; m0w = mv_cnt_w;
    btn_n[DIR_UP] = 1'b0;
    btn_n[DIR_DOWN] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      cyc(1);
      if (c == 10) btn_n[DIR_RIGHT] = 1'b0;
      if (c == 20) btn_n[DIR_RIGHT] = 1'b1;
      if (c == 30) check_val("conflict_held", heldc, 4'b1100);
    end
    btn_n[DIR_UP] = 1'b1;
    btn_n[DIR_DOWN] = 1'b1;
    cyc(12);
    check_val("conflict_y_c", yc, hd_c[6]);
    check_val("conflict_y_w", yw, hd_w[6]);
    check_val("conflict_x_c", xc, 4);
    check_val("conflict_x_w", xw, 0);
    check_val("conflict_moved_c", mv_cnt_c - m0c, 1);
    check_val("conflict_moved_w", mv_cnt_w - m0w, 1);

    // Reset pulse while right is held in repeat.
    btn_n[DIR_RIGHT] = 1'b0;
    for (int c = 1; c <= 39; c++) begin
      cyc(1);
      if (c == 38) begin
        check_val("rpt_x_c", xc, rp_c);
        check_val("rpt_x_w", xw, rp_w);
      end
    end
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    check_val("rst2_x_c", xc, 8);
    check_val("rst2_x_w", xw, 8);
    check_val("rst2_y_c", yc, 6);
    check_val("rst2_held", heldc, 0);
    cyc(6);
    check_val("rst2_x_e6", xc, 8);
    cyc(1);
    check_val("rst2_x_c_e7", xc, 12);
    check_val("rst2_x_w_e7", xw, 12);
    check_val("rst2_moved_e7", mvc, 1);
    btn_n[DIR_RIGHT] = 1'b1;
    cyc(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Parametrised four-button cursor controller that turns raw up/down/left/right push-buttons into a debounced, clamped or wrapped (x, y) screen position. It sits between the board KEY inputs and the VGA pixel generator, replacing ad-hoc button handling inside the VGA controller, and generalises it with configurable resolution, step size, edge mode and hold-to-repeat.

## Interface
Parameters:
- H_RES, 640: horizontal extent; x_pos range 0..H_RES-1
- V_RES, 480: vertical extent; y_pos range 0..V_RES-1
- STEP, 4: pixels moved per step event; 1 ≤ STEP < min(H_RES, V_RES)
- DEB_CYCLES, 250000: consecutive stable samples required to accept a level change
- RPT_DELAY, 25000000: cycles held before the first repeat
- RPT_PERIOD, 5000000: cycles between subsequent repeats
- WRAP, 0: 0 = clamp at edges, 1 = wrap modulo H_RES/V_RES

Ports:
- clock  in  1  single system clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- up, down, left, right  in  1 each  raw buttons, active-low, asynchronous to clock
- x_pos  out  $clog2(H_RES)  cursor column
- y_pos  out  $clog2(V_RES)  cursor row
- held  out  4  debounced pressed levels, {up, down, left, right}, active-high
- moved  out  1  one-cycle pulse when x_pos or y_pos changed this cycle

## Operation
- Each button: 2-flop synchroniser, invert to active-high, then debouncer. Debounced level flips only after DEB_CYCLES consecutive synchronised samples differing from it; any agreeing sample clears the counter.
- Press event = debounced 0→1. Release produces no step.
- Per-axis step request: x axis from left/right, y axis from up/down. Both buttons of one axis pressed (debounced) → axis requests nothing; the other axis is unaffected. Axes may step in the same cycle.
- Arithmetic: right/down add STEP, left/up subtract. Compute in width+1 bits. WRAP=0: result <0 → 0, result >RES-1 → RES-1. WRAP=1: result taken modulo RES (e.g. 0−STEP → RES−STEP).
- moved asserts only if a position value actually changes (clamped no-op step → moved=0).
- Reset (resetn=0 at clock edge): x_pos=H_RES/2, y_pos=V_RES/2, held=0, moved=0, all counters and FSMs idle. A button held through reset is seen as a new press once DEB_CYCLES elapse after reset release.

## Timing
- Latency raw edge → first position change: 2 (sync) + DEB_CYCLES + 1 (position register) cycles; moved coincides with the new position.
- held changes on the same cycle the debouncer accepts a level, one cycle before the resulting position update.
- Repeat FSM per axis, states IDLE → DELAY → REPEAT:
  - IDLE: press event → step, go DELAY, load RPT_DELAY.
  - DELAY: count down; reaching zero → step, go REPEAT, load RPT_PERIOD.
  - REPEAT: each RPT_PERIOD expiry → step.
  - Any state: axis button released or axis conflict (both pressed) → IDLE, no step. Switching direction within the axis (release one, press the other) restarts from IDLE.

## Configuration
- CURSOR_AUTOREPEAT_EN defined: DELAY/REPEAT states and counters compiled in, behaviour as above.
- Not defined: FSM reduced to IDLE only; exactly one step per press event; RPT_DELAY/RPT_PERIOD ignored.

## Structure
- Package cursor_pkg: direction index constants DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0; repeat FSM state encoding (RPT_IDLE, RPT_DELAY, RPT_REPEAT).
- Sub-module btn_debounce (synchroniser + debouncer, parameter DEB_CYCLES), instantiated four times; axis FSMs and position arithmetic in cursor_ctrl.

## Test plan
Bench parameters: H_RES=16, V_RES=12, STEP=4, DEB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8, WRAP=0, macro defined unless stated.
- Reset then idle 50 cycles → x_pos=8, y_pos=6, held=0, moved never high.
- right low for 3 cycles then high (glitch) → no held change, x_pos=8; right low 10 cycles → x_pos=12 exactly 7 cycles after falling edge, moved one cycle.
- From x_pos=4 press left twice → 0, then 0 with moved=0; rerun WRAP=1 → 0 then 12.
- Hold down 60 cycles from y_pos=0 (WRAP=1) → steps at debounce, +20, +28, +36, … giving y 4, 8, 0, 4; macro undefined → single step to 4.
- Press up and down together 40 cycles → y_pos unchanged, moved 0; simultaneous left press still moves x.
- Hold right in REPEAT, assert resetn=0 one cycle while held → x_pos=8, held=0 next cycle; first new step DEB_CYCLES+3 cycles after reset release.
